mcp3008_responder: RTL

MCP3008_RESPONDER -- requirements
Module: mcp3008_responder

---
 rtl/mcp3008_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mcp3008_responder.sv
// MCP3008-style SPI ADC responder: decodes start/SGL/D2..D0 commands and serves channel values.
// Optional build macro MCP3008_LSB_TRAIL_EN enables the LSB-first repeat after B0.
module mcp3008_responder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       AD_CLK,
  input  logic       CS,
  input  logic       DIN,
  output logic       DOUT,
  output logic       dout_oe,
  input  logic       wr_en,
  input  logic [2:0] wr_ch,
  input  logic [9:0] wr_data,
  output logic       conv_done,
  output logic [2:0] conv_ch,
  output logic       conv_sgl,
  output logic [2:0] dbg_state
);

  // Handshake: wr_en is a single-cycle strobe with no back-pressure; the write
  // lands on the same posedge it is sampled high. conv_done is a one-cycle pulse.

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    NULLBIT    = 3'd3,
    DATA       = 3'd4,
    TRAIL      = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  adclk_s;
  logic        adclk_d;
  logic [1:0]  cs_s;
  logic [1:0]  din_s;
  logic [1:0]  fill;
  logic        armed;
  logic [3:0]  bit_cnt;
  logic        cmd_sgl;
  logic        cmd_d2;
  logic        cmd_d1;
  logic [2:0]  cmd_ch;
  logic [9:0]  result;
  logic [9:0]  ch_mem [8];

  logic        ad_rise;
  logic        ad_fall;
  logic        cs_high;
  logic        din_b;
  logic [2:0]  sel_ch;
  logic [9:0]  val_a;
  logic [9:0]  val_b;
  logic [10:0] diff;
  logic [9:0]  conv_val;

  assign ad_rise   = adclk_s[1] & ~adclk_d;
  assign ad_fall   = ~adclk_s[1] & adclk_d;
  assign cs_high   = cs_s[1];
  assign din_b     = din_s[1];
  assign dbg_state = state;

  // Result is formed on the D0 rise from the incoming bit and the stored D2/D1.
  assign sel_ch   = {cmd_d2, cmd_d1, din_b};
  assign val_a    = ch_mem[sel_ch];
  assign val_b    = ch_mem[sel_ch ^ 3'd1];
  assign diff     = {1'b0, val_a} - {1'b0, val_b};
  assign conv_val = cmd_sgl ? val_a : (diff[10] ? 10'd0 : diff[9:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adclk_s <= 2'b00;
      adclk_d <= 1'b0;
      cs_s    <= 2'b11;
      din_s   <= 2'b00;
      fill    <= 2'b00;
    end else begin
      adclk_s <= {adclk_s[0], AD_CLK};
      adclk_d <= adclk_s[1];
      cs_s    <= {cs_s[0], CS};
      din_s   <= {din_s[0], DIN};
      fill    <= {fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) ch_mem[i] <= 10'd0;
    end else if (wr_en) begin
      ch_mem[wr_ch] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      DOUT      <= 1'b0;
      dout_oe   <= 1'b0;
      conv_done <= 1'b0;
      conv_ch   <= 3'd0;
      conv_sgl  <= 1'b0;
      armed     <= 1'b0;
      bit_cnt   <= 4'd0;
      cmd_sgl   <= 1'b0;
      cmd_d2    <= 1'b0;
      cmd_d1    <= 1'b0;
      cmd_ch    <= 3'd0;
      result    <= 10'd0;
    end else begin
      conv_done <= 1'b0;
      if (cs_high) begin
        // CS high beats any coincident AD_CLK edge; fill gates the reset-value CS.
        state   <= IDLE;
        DOUT    <= 1'b0;
        dout_oe <= 1'b0;
        bit_cnt <= 4'd0;
        if (fill[1]) armed <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            DOUT    <= 1'b0;
            dout_oe <= 1'b0;
            if (armed) begin
              state <= WAIT_START;
              armed <= 1'b0;
            end
          end
          WAIT_START: begin
            if (ad_rise && din_b) begin
              state   <= CMD;
              bit_cnt <= 4'd0;
            end
          end
          CMD: begin
            if (ad_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              case (bit_cnt[1:0])
                2'd0: cmd_sgl <= din_b;
                2'd1: cmd_d2  <= din_b;
                2'd2: cmd_d1  <= din_b;
                default: begin
                  cmd_ch <= sel_ch;
                  result <= conv_val;
                  state  <= NULLBIT;
                end
              endcase
            end
          end
          NULLBIT: begin
            if (ad_fall) begin
              dout_oe <= 1'b1;
              DOUT    <= 1'b0;
              bit_cnt <= 4'd9;
              state   <= DATA;
            end
          end
          DATA: begin
            if (ad_fall) begin
              DOUT <= result[bit_cnt];
              if (bit_cnt == 4'd0) begin
                conv_done <= 1'b1;
                conv_ch   <= cmd_ch;
                conv_sgl  <= cmd_sgl;
                bit_cnt   <= 4'd1;
                state     <= TRAIL;
              end else begin
                bit_cnt <= bit_cnt - 4'd1;
              end
            end
          end
          TRAIL: begin
            if (ad_fall) begin
`ifdef MCP3008_LSB_TRAIL_EN
              if (bit_cnt <= 4'd9) begin
                DOUT    <= result[bit_cnt];
                bit_cnt <= bit_cnt + 4'd1;
              end else begin
                DOUT <= 1'b0;
              end
`else
              DOUT <= 1'b0;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
